// File: rtl/cache_set_nway_if.sv
// Core-side request/response and memory-side writeback/fill signals of one cache set.
// The cache takes the slave view; the requester plus next-level memory take the master view.
interface cache_set_nway_if #(
  parameter int TAG_W    = 24,
  parameter int OFFSET_W = 5,
  parameter int BLOCK_W  = 256
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [TAG_W-1:0]    req_tag;
  logic [OFFSET_W-1:0] req_offset;
  logic [7:0]          req_byte;
  logic                resp_valid;
  logic                resp_hit;
  logic [7:0]          resp_byte;
  logic [BLOCK_W-1:0]  resp_data;
  logic                wb_valid;
  logic                wb_ready;
  logic [TAG_W-1:0]    wb_tag;
  logic [BLOCK_W-1:0]  wb_data;
  logic                fill_req;
  logic [TAG_W-1:0]    fill_tag;
  logic                fill_valid;
  logic [BLOCK_W-1:0]  fill_data;

  modport slave (
    input  req_valid, req_write, req_tag, req_offset, req_byte, wb_ready, fill_valid, fill_data,
    output req_ready, resp_valid, resp_hit, resp_byte, resp_data,
           wb_valid, wb_tag, wb_data, fill_req, fill_tag
  );

  modport master (
    output req_valid, req_write, req_tag, req_offset, req_byte, wb_ready, fill_valid, fill_data,
    input  req_ready, resp_valid, resp_hit, resp_byte, resp_data,
           wb_valid, wb_tag, wb_data, fill_req, fill_tag
  );
endinterface

// File: rtl/cache_set_nway.sv
// One index of an N-way set-associative cache: true-LRU ages, byte read/write,
// dirty-victim writeback and fill from the next level, one request in flight.
module cache_set_nway #(
  parameter int WAYS     = 8,
  parameter int TAG_W    = 24,
  parameter int OFFSET_W = 5,
  parameter int BLOCK_W  = 256
) (
  input logic clk,
  input logic reset,
  cache_set_nway_if.slave bus
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
  state_t state, stateNext;

  logic [WAYS-1:0]     validQ, dirtyQ;
  logic [TAG_W-1:0]    tagQ  [WAYS];
  logic [BLOCK_W-1:0]  dataQ [WAYS];
  logic [WAY_W-1:0]    ageQ  [WAYS];

  logic                rWrite;
  logic [TAG_W-1:0]    rTag;
  logic [OFFSET_W-1:0] rOffset;
  logic [7:0]          rByte;
  logic [WAY_W-1:0]    victimQ;

  logic                respValidQ, respHitQ;
  logic [7:0]          respByteQ;
  logic [BLOCK_W-1:0]  respDataQ;

  logic [WAYS-1:0]     matchVec;
  logic                hit, doUpdate;
  logic [WAY_W-1:0]    hitWay, victimWay, updWay;
  logic [BLOCK_W-1:0]  srcBlk, lineNew;

  function automatic logic [BLOCK_W-1:0] mergeByte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off,
                                                   input logic [7:0] b);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : gMatch
    assign matchVec[w] = validQ[w] && (tagQ[w] == rTag);
  end

  // Downward scans so the lowest index wins on both match and invalid-way choice.
  always_comb begin
    hit       = |matchVec;
    hitWay    = '0;
    victimWay = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (matchVec[w]) hitWay = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (ageQ[w] == WAY_W'(WAYS-1)) victimWay = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!validQ[w]) victimWay = WAY_W'(w);
  end

  always_comb begin
    doUpdate = (state == LOOKUP && hit) || (state == FILL && bus.fill_valid);
    updWay   = (state == LOOKUP) ? hitWay : victimQ;
    srcBlk   = (state == LOOKUP) ? dataQ[hitWay] : bus.fill_data;
    lineNew  = rWrite ? mergeByte(srcBlk, rOffset, rByte) : srcBlk;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= stateNext;

  always_comb begin
    stateNext     = state;
    bus.req_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_tag    = '0;
    bus.wb_data   = '0;
    bus.fill_req  = 1'b0;
    bus.fill_tag  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) stateNext = LOOKUP;
      end
      LOOKUP: begin
        if (hit)                                         stateNext = IDLE;
        else if (validQ[victimWay] && dirtyQ[victimWay]) stateNext = WB;
        else                                             stateNext = FILL;
      end
      WB: begin
        bus.wb_valid = 1'b1;
        bus.wb_tag   = tagQ[victimQ];
        bus.wb_data  = dataQ[victimQ];
        if (bus.wb_ready) stateNext = FILL;
      end
      FILL: begin
        bus.fill_req = 1'b1;
        bus.fill_tag = rTag;
        if (bus.fill_valid) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validQ     <= '0;
      dirtyQ     <= '0;
      rWrite     <= 1'b0;
      rTag       <= '0;
      rOffset    <= '0;
      rByte      <= '0;
      victimQ    <= '0;
      respValidQ <= 1'b0;
      respHitQ   <= 1'b0;
      respByteQ  <= '0;
      respDataQ  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tagQ[w]  <= '0;
        dataQ[w] <= '0;
        ageQ[w]  <= WAY_W'(w);
      end
    end else begin
      respValidQ <= 1'b0;
      if (state == IDLE && bus.req_valid) begin
        rWrite  <= bus.req_write;
        rTag    <= bus.req_tag;
        rOffset <= bus.req_offset;
        rByte   <= bus.req_byte;
      end
      if (state == LOOKUP && !hit) victimQ <= victimWay;
      if (state == WB && bus.wb_ready) dirtyQ[victimQ] <= 1'b0;
      if (doUpdate) begin
        dataQ[updWay] <= lineNew;
        // Ages younger than the touched way shift back by one; touched way becomes MRU.
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == updWay)        ageQ[w] <= '0;
          else if (ageQ[w] < ageQ[updWay]) ageQ[w] <= ageQ[w] + 1'b1;
        if (state == FILL) begin
          validQ[updWay] <= 1'b1;
          tagQ[updWay]   <= rTag;
          dirtyQ[updWay] <= rWrite;
        end else if (rWrite) begin
          dirtyQ[updWay] <= 1'b1;
        end
        respValidQ <= 1'b1;
        respHitQ   <= (state == LOOKUP);
        respDataQ  <= lineNew;
        respByteQ  <= lineNew[{rOffset, 3'b000} +: 8];
      end
    end
  end

  assign bus.resp_valid = respValidQ;
  assign bus.resp_hit   = respHitQ;
  assign bus.resp_byte  = respByteQ;
  assign bus.resp_data  = respDataQ;
endmodule

// File: tb/tb_cache_set_nway.sv
// Directed bench for cache_set_nway: hit/miss latency, LRU victim choice,
// dirty writeback stall, reset during fill, request stalling and stray fill pulses.
module tb_cache_set_nway;
  localparam int WAYS = 8, TAG_W = 24, OFFSET_W = 5, BLOCK_W = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0, errors = 0, accepts = 0;

  cache_set_nway_if #(.TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .BLOCK_W(BLOCK_W)) bus();

  cache_set_nway #(.WAYS(WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .BLOCK_W(BLOCK_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.req_valid && bus.req_ready) accepts <= accepts + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BLOCK_W-1:0] pat(input logic [7:0] seed);
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = seed + 8'(k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [TAG_W-1:0] tag, input logic [OFFSET_W-1:0] off,
                       input logic [7:0] b);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_tag    = tag;
    bus.req_offset = off;
    bus.req_byte   = b;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic readMissClean(input logic [TAG_W-1:0] tag, input logic [OFFSET_W-1:0] off,
                               input logic [7:0] seed);
    issue(1'b0, tag, off, 8'h00);
    check("lookup_ready", bus.req_ready, 0);
    tick();
    check("miss_fill_req", bus.fill_req, 1);
    check("miss_fill_tag", bus.fill_tag, tag);
    check("miss_no_wb", bus.wb_valid, 0);
    bus.fill_valid = 1'b1;
    bus.fill_data  = pat(seed);
    tick();
    bus.fill_valid = 1'b0;
    check("miss_resp_valid", bus.resp_valid, 1);
    check("miss_resp_hit", bus.resp_hit, 0);
    check("miss_resp_byte", bus.resp_byte, seed + 8'(off));
    tick();
  endtask

  task automatic hitAccess(input logic wr, input logic [TAG_W-1:0] tag, input logic [OFFSET_W-1:0] off,
                           input logic [7:0] b, input logic [7:0] expByte);
    issue(wr, tag, off, b);
    check("hit_lookup_no_resp", bus.resp_valid, 0);
    tick();
    check("hit_resp_valid", bus.resp_valid, 1);
    check("hit_resp_hit", bus.resp_hit, 1);
    check("hit_resp_byte", bus.resp_byte, expByte);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_tag = '0; bus.req_offset = '0;
    bus.req_byte = '0; bus.wb_ready = 1'b0; bus.fill_valid = 1'b0; bus.fill_data = '0;

    tick(); tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_fill_req", bus.fill_req, 0);
    check("rst_resp_data", bus.resp_data, 0);
    reset = 1'b1;
    tick();

    // First read miss with req_valid held through the whole transaction.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_tag = 24'h000ABC; bus.req_offset = 5'd3;
    tick();
    check("stall_ready_lookup", bus.req_ready, 0);
    tick();
    check("a_fill_req", bus.fill_req, 1);
    check("a_fill_tag", bus.fill_tag, 24'h000ABC);
    check("a_no_wb", bus.wb_valid, 0);
    bus.fill_valid = 1'b1;
    bus.fill_data  = pat(8'h57);
    tick();
    bus.fill_valid = 1'b0;
    bus.req_valid  = 1'b0;
    check("a_resp_valid", bus.resp_valid, 1);
    check("a_resp_hit", bus.resp_hit, 0);
    check("a_resp_byte", bus.resp_byte, 8'h5A);
    check("a_single_accept", accepts, 1);
    tick();
    check("a_resp_pulse", bus.resp_valid, 0);
    check("a_resp_byte_hold", bus.resp_byte, 8'h5A);

    hitAccess(1'b0, 24'h000ABC, 5'd3, 8'h00, 8'h5A);
    hitAccess(1'b1, 24'h000ABC, 5'd31, 8'hC3, 8'hC3);
    check("wr_data_top", bus.resp_data[255:248], 8'hC3);
    check("wr_data_b3", bus.resp_data[31:24], 8'h5A);

    for (int k = 1; k < 8; k++) readMissClean(24'h000100 + 24'(k), 5'd2, 8'(k * 16));

    // Way 0 (dirty 0xABC) is now LRU: miss on 0x108 must write it back first.
    issue(1'b0, 24'h000108, 5'd0, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wb_valid_stall", bus.wb_valid, 1);
      check("wb_tag_stall", bus.wb_tag, 24'h000ABC);
      check("wb_no_fill_req", bus.fill_req, 0);
      tick();
    end
    check("wb_data_top", bus.wb_data[255:248], 8'hC3);
    check("wb_data_b3", bus.wb_data[31:24], 8'h5A);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    check("wb_done", bus.wb_valid, 0);
    check("wb_then_fill", bus.fill_req, 1);
    check("wb_fill_tag", bus.fill_tag, 24'h000108);
    bus.fill_valid = 1'b1;
    bus.fill_data  = pat(8'h80);
    tick();
    bus.fill_valid = 1'b0;
    check("t8_resp_hit", bus.resp_hit, 0);
    check("t8_resp_byte", bus.resp_byte, 8'h80);
    tick();

    // Touch 0x101 so 0x102 becomes the LRU victim for the next clean miss.
    hitAccess(1'b0, 24'h000101, 5'd2, 8'h00, 8'h12);
    readMissClean(24'h000109, 5'd5, 8'h90);
    hitAccess(1'b0, 24'h000101, 5'd2, 8'h00, 8'h12);
    hitAccess(1'b0, 24'h000103, 5'd2, 8'h00, 8'h32);
    hitAccess(1'b0, 24'h000109, 5'd5, 8'h00, 8'h95);

    // 0x102 was evicted: it misses; reset lands while waiting for the fill.
    issue(1'b0, 24'h000102, 5'd2, 8'h00);
    tick();
    check("evicted_misses", bus.fill_req, 1);
    #1 reset = 1'b0;
    #1;
    check("arst_req_ready", bus.req_ready, 1);
    check("arst_fill_req", bus.fill_req, 0);
    check("arst_fill_tag", bus.fill_tag, 0);
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_resp_byte", bus.resp_byte, 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_no_resp", bus.resp_valid, 0);
    readMissClean(24'h000101, 5'd2, 8'h20);

    // Stray fill pulse while idle must be ignored.
    bus.fill_valid = 1'b1;
    bus.fill_data  = pat(8'hEE);
    tick();
    bus.fill_valid = 1'b0;
    check("stray_fill_ready", bus.req_ready, 1);
    check("stray_fill_req", bus.fill_req, 0);
    check("stray_fill_resp", bus.resp_valid, 0);
    hitAccess(1'b0, 24'h000101, 5'd2, 8'h00, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
